serial_operand_feeder: RTL and testbench
========================================

Name: serial_operand_feeder

Overview:
Upstream stage of the bit-serial adder. It accepts two parallel WIDTH-bit operands through a valid/ready handshake, then streams them out LSB-first on a/b, one bit pair per clock. It precedes each frame with a one-cycle adder carry-clear pulse. It optionally appends zero flush cycles so the final carry appears on the adder's sum output.

Parameters:
WIDTH, 4, operand width in bits (>=2)
FLUSH_BITS, 1, number of trailing zero bit-pairs after the MSB (0 = no flush)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  operands on op_a/op_b are valid
in_ready  output  1  block can accept operands this cycle
op_a  input  WIDTH  operand A, parallel
op_b  input  WIDTH  operand B, parallel
a  output  1  serial operand A bit to the adder
b  output  1  serial operand B bit to the adder
adder_clr  output  1  one-cycle active-high clear of the adder carry state
busy  output  1  a frame is in progress
last_bit  output  1  marks the final bit-pair of the frame (MSB, or last flush bit)

Behaviour:
- Reset (reset=0, async): state=IDLE; shift registers, counter, a, b, adder_clr, last_bit and busy all 0. in_ready is forced to 0 while reset=0.
- States: IDLE, CLEAR, SHIFT, FLUSH. Two-bit encoding.
- IDLE:
  - in_ready=1; a=b=0; busy=0.
  - On in_valid & in_ready at a rising edge: capture op_a→sa and op_b→sb, clear the counter, go to CLEAR.
- CLEAR (1 cycle):
  - adder_clr=1; a=b=0; busy=1.
  - Next state is SHIFT.
- SHIFT (WIDTH cycles):
  - a=sa[0], b=sb[0]; busy=1.
  - Each edge: sa and sb shift right with zero fill; counter increments.
  - At count==WIDTH-1, go to FLUSH if FLUSH_BITS>0, otherwise IDLE.
  - last_bit=1 in the count==WIDTH-1 cycle only when FLUSH_BITS==0.
- FLUSH (FLUSH_BITS cycles):
  - a=b=0; busy=1.
  - last_bit=1 in the final flush cycle.
  - Then go to IDLE.
- Output timing:
  - All outputs are functions of registered state only. No combinational path from in_valid or op_* to any output except in_ready, which depends on state only.
- Latency and throughput:
  - Handshake at edge k. adder_clr is high in cycle k..k+1. Bit i is driven in cycle k+2+i.
  - A frame occupies 1+WIDTH+FLUSH_BITS busy cycles followed by at least one IDLE cycle, so there is no back-to-back acceptance.
- in_ready is 0 in every non-IDLE state. Changes to in_valid or op_* mid-frame are ignored; captured data is held.
- Counter width is $clog2(WIDTH+FLUSH_BITS)+1. No wrap-around is possible within a frame.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The partial frame is dropped and never resumed. The adder receives its own reset from the system.
- in_valid held high continuously: a new frame starts at every IDLE cycle, giving period 2+WIDTH+FLUSH_BITS.

Decomposition:
- Shared package (localparams): state encodings ST_IDLE=0, ST_CLEAR=1, ST_SHIFT=2, ST_FLUSH=3; default WIDTH and FLUSH_BITS. Also include these in the serial-adder bench environment.
- One natural sub-module: piso_shift_reg (WIDTH-bit parallel-load, shift-right, zero-fill, with load/shift enables), instantiated twice for A and B. The FSM and counter stay in the top.

Test Plan:
- Reset release, in_valid=0 -> in_ready=1, a=b=adder_clr=busy=last_bit=0 on all cycles.
- WIDTH=4, FLUSH_BITS=1, op_a=4'b1011, op_b=4'b0111 -> adder_clr for 1 cycle, then a=1,1,0,1,0 and b=1,1,1,0,0; last_bit only on the 5th bit. A chained serial adder gives s=0,1,0,0,1 (18).
- in_valid held high, op_a=4'hF, op_b=4'h1 -> frames repeat every 7 cycles; in_ready=0 throughout each frame. a=1,1,1,1,0 and b=1,0,0,0,0; adder yields 0,0,0,0,1 (16).
- Change op_a/op_b and pulse in_valid mid-SHIFT -> streamed bits unchanged; no second capture until IDLE.
- Assert reset=0 in the 2nd SHIFT cycle -> same cycle a=b=busy=in_ready=0. After release, IDLE with in_ready=1 and no residual bits emitted.
- FLUSH_BITS=0, op_a=4'b1000, op_b=4'b1000 -> 4 SHIFT cycles, last_bit on the MSB cycle (a=b=1), IDLE next.

Source files
------------

// File: rtl/serial_operand_feeder_pkg.sv
// Shared constants for the serial operand feeder: FSM state encoding and default geometry.
package serial_operand_feeder_pkg;

    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_FLUSH_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/serial_operand_feeder_if.sv
// Operand handshake plus serial adder-facing outputs of the feeder.
interface serial_operand_feeder_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             a;
    logic             b;
    logic             adder_clr;
    logic             busy;
    logic             last_bit;

    modport master (
        output in_valid, op_a, op_b,
        input  in_ready, a, b, adder_clr, busy, last_bit
    );

    modport slave (
        input  in_valid, op_a, op_b,
        output in_ready, a, b, adder_clr, busy, last_bit
    );
endinterface

// File: rtl/serial_operand_feeder_piso_shift_reg.sv
// Parallel-in serial-out register: load wins over shift, shifts right with zero fill, LSB on dout.
module piso_shift_reg
    import serial_operand_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
    end

    assign dout = sreg[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Captures two operands and streams them LSB-first after a one-cycle carry clear, plus optional zero flush.
// Bit i appears 2+i cycles after the handshake edge; in_ready only in IDLE, so frames never overlap.
module serial_operand_feeder
    import serial_operand_feeder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int FLUSH_BITS = DEFAULT_FLUSH_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_operand_feeder_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + FLUSH_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(WIDTH + FLUSH_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift;
    logic             sa_bit, sb_bit;
    logic             in_ready_c, a_c, b_c, clr_c, busy_c, last_c;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sa (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (bus.op_a),
        .dout  (sa_bit)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sb (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (bus.op_b),
        .dout  (sb_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
        in_ready_c = 1'b0;
        a_c        = 1'b0;
        b_c        = 1'b0;
        clr_c      = 1'b0;
        busy_c     = 1'b0;
        last_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by reset so the handshake never appears accepted while held in reset.
                in_ready_c = reset;
                if (bus.in_valid && reset) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_c   = 1'b1;
                busy_c  = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_c    = sa_bit;
                b_c    = sb_bit;
                busy_c = 1'b1;
                shift  = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    last_c  = (FLUSH_BITS == 0);
                    state_d = (FLUSH_BITS > 0) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                busy_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_FLUSH) begin
                    last_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.a         = a_c;
    assign bus.b         = b_c;
    assign bus.adder_clr = clr_c;
    assign bus.busy      = busy_c;
    assign bus.last_bit  = last_c;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench: vector table on a WIDTH=4/FLUSH_BITS=1 feeder with a serial adder model, plus reset and no-flush sequences.
module tb_serial_operand_feeder;
    import serial_operand_feeder_pkg::*;

    typedef struct {
        logic       vld;
        logic [3:0] oa;
        logic [3:0] ob;
        logic       rdy;
        logic       a;
        logic       b;
        logic       clr;
        logic       busy;
        logic       last;
        logic [7:0] sum;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    serial_operand_feeder_if #(.WIDTH(DEFAULT_WIDTH)) bus1 ();
    serial_operand_feeder_if #(.WIDTH(DEFAULT_WIDTH)) bus0 ();

    serial_operand_feeder #(.WIDTH(DEFAULT_WIDTH), .FLUSH_BITS(DEFAULT_FLUSH_BITS)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    serial_operand_feeder #(.WIDTH(DEFAULT_WIDTH), .FLUSH_BITS(0)) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chained bit-serial adder fed by dut1.
    logic carry;
    logic s;
    assign s = bus1.a ^ bus1.b ^ carry;
    always @(posedge clk or negedge rst) begin
        if (!rst)                carry <= 1'b0;
        else if (bus1.adder_clr) carry <= 1'b0;
        else                     carry <= (bus1.a & bus1.b) | (bus1.a & carry) | (bus1.b & carry);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [3:0] oa, input logic [3:0] ob,
                       input logic rdy, input logic a, input logic b, input logic clr,
                       input logic busy, input logic last, input logic [7:0] sum);
        vec_t v;
        v.vld = vld; v.oa = oa; v.ob = ob; v.rdy = rdy; v.a = a; v.b = b;
        v.clr = clr; v.busy = busy; v.last = last; v.sum = sum;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] acc;
        int         idx;
        checks = 0;
        errors = 0;
        acc    = '0;
        idx    = 0;

        //   vld oa    ob    rdy a  b  clr busy last sum
        add(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 4'hB, 4'h7, 1, 0, 0, 0, 0, 0, 0);
        add(0, 4'h5, 4'h5, 0, 0, 0, 1, 1, 0, 0);
        add(0, 4'h0, 4'h0, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'h0, 4'h0, 0, 1, 1, 0, 1, 0, 0);
        add(0, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 4'h0, 4'h0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 18);
        add(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        // in_valid held high: frame period 7
        add(1, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 4'hF, 4'h1, 0, 0, 0, 1, 1, 0, 0);
        add(1, 4'hF, 4'h1, 0, 1, 1, 0, 1, 0, 0);
        add(1, 4'hF, 4'h1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 4'hF, 4'h1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 4'hF, 4'h1, 0, 1, 0, 0, 1, 0, 0);
        add(1, 4'hF, 4'h1, 0, 0, 0, 0, 1, 1, 16);
        add(1, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0);
        // operands and in_valid disturbed mid-frame: captured data must hold
        add(1, 4'h0, 4'hE, 0, 0, 0, 1, 1, 0, 0);
        add(0, 4'h2, 4'h6, 0, 1, 1, 0, 1, 0, 0);
        add(1, 4'h0, 4'h0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 4'h9, 4'hA, 0, 1, 0, 0, 1, 0, 0);
        add(1, 4'h0, 4'h0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 4'h3, 4'h3, 0, 0, 0, 0, 1, 1, 16);
        add(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0);

        rst = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
        bus0.in_valid = 1'b0; bus0.op_a = '0; bus0.op_b = '0;
        #1;
        chk("reset rdy", {7'd0, bus1.in_ready}, 8'd0);
        chk("reset outs", {3'd0, bus1.a, bus1.b, bus1.adder_clr, bus1.busy, bus1.last_bit}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus1.in_valid = vecs[i].vld;
            bus1.op_a     = vecs[i].oa;
            bus1.op_b     = vecs[i].ob;
            #1;
            chk($sformatf("v%0d rdy", i),  {7'd0, bus1.in_ready},  {7'd0, vecs[i].rdy});
            chk($sformatf("v%0d a", i),    {7'd0, bus1.a},         {7'd0, vecs[i].a});
            chk($sformatf("v%0d b", i),    {7'd0, bus1.b},         {7'd0, vecs[i].b});
            chk($sformatf("v%0d clr", i),  {7'd0, bus1.adder_clr}, {7'd0, vecs[i].clr});
            chk($sformatf("v%0d busy", i), {7'd0, bus1.busy},      {7'd0, vecs[i].busy});
            chk($sformatf("v%0d last", i), {7'd0, bus1.last_bit},  {7'd0, vecs[i].last});
            if (bus1.adder_clr) begin
                acc = '0;
                idx = 0;
            end else if (bus1.busy) begin
                acc[idx] = s;
                idx++;
            end
            if (vecs[i].last) chk($sformatf("v%0d sum", i), acc, vecs[i].sum);
        end

        // Reset asserted in the second SHIFT cycle.
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.op_a = 4'h2; bus1.op_b = 4'h2;
        #1 chk("rst seq rdy", {7'd0, bus1.in_ready}, 8'd1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1 chk("rst seq clr", {7'd0, bus1.adder_clr}, 8'd1);
        @(negedge clk);
        #1 chk("rst seq bit0", {6'd0, bus1.a, bus1.b}, 8'd0);
        @(negedge clk);
        #1 chk("rst seq bit1", {5'd0, bus1.a, bus1.b, bus1.busy}, 8'h7);
        rst = 1'b0;
        #1 chk("rst seq async", {4'd0, bus1.a, bus1.b, bus1.busy, bus1.in_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1 chk($sformatf("post rst %0d", k),
                   {3'd0, bus1.in_ready, bus1.a, bus1.b, bus1.busy, bus1.last_bit}, 8'h10);
        end

        // No-flush instance: last_bit on the MSB, straight back to IDLE.
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.op_a = 4'h8; bus0.op_b = 4'h8;
        #1 chk("nf rdy", {7'd0, bus0.in_ready}, 8'd1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1 chk("nf clr", {6'd0, bus0.adder_clr, bus0.busy}, 8'h3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk($sformatf("nf bit%0d", k),
                   {4'd0, bus0.a, bus0.b, bus0.busy, bus0.last_bit},
                   (k == 3) ? 8'hF : 8'h2);
        end
        @(negedge clk);
        #1 chk("nf idle", {3'd0, bus0.in_ready, bus0.a, bus0.b, bus0.busy, bus0.last_bit}, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
